// File: rtl/mul_div_unit_if.sv
// Issue/result handshake bundle between the execute stage (master) and the
// iterative multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int N = 64
) ();
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [N-1:0] dataA;
  logic [N-1:0] dataB;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         Zero;
  logic         Negative;

  modport master (
    output flush, in_valid, op, dataA, dataB, out_ready,
    input  in_ready, out_valid, out, Zero, Negative
  );

  modport slave (
    input  flush, in_valid, op, dataA, dataB, out_ready,
    output in_ready, out_valid, out, Zero, Negative
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension unit: one radix-2 step per cycle
// (shift-add multiply, restoring divide) with a fast path for /0 and overflow.
module mul_div_unit #(
  parameter int N = 64
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave io_md
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_state_next;
  logic [2:0]      r_op;
  logic            r_neg_a, r_neg_b;
  logic [N-1:0]    r_a_mag, r_b_mag;
  logic [2*N-1:0]  r_prod;
  logic [N-1:0]    r_quot;
  logic [N:0]      r_rem;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_out;
  logic            r_zero, r_neg;

  logic            w_accept, w_sign_a, w_sign_b, w_neg_a, w_neg_b;
  logic [N-1:0]    w_a_mag, w_b_mag;
  logic            w_div_zero, w_ovf, w_fast;
  logic [N-1:0]    w_fast_res;
  logic [N:0]      w_mul_sum;
  logic [N+1:0]    w_div_shift, w_div_diff;
  logic            w_div_ge;
  logic [2*N-1:0]  w_prod_fix;
  logic [N-1:0]    w_quot_fix, w_rem_fix, w_fix_res;

  assign w_accept = (r_state == S_IDLE) && io_md.in_valid && !io_md.flush;

  // Signed-operand selection: MULH/DIV/REM sign both, MULHSU signs only A.
  assign w_sign_a = (io_md.op == 3'd1) || (io_md.op == 3'd2) ||
                    (io_md.op == 3'd4) || (io_md.op == 3'd6);
  assign w_sign_b = (io_md.op == 3'd1) || (io_md.op == 3'd4) || (io_md.op == 3'd6);
  assign w_neg_a  = w_sign_a && io_md.dataA[N-1];
  assign w_neg_b  = w_sign_b && io_md.dataB[N-1];
  assign w_a_mag  = w_neg_a ? (~io_md.dataA + 1'b1) : io_md.dataA;
  assign w_b_mag  = w_neg_b ? (~io_md.dataB + 1'b1) : io_md.dataB;

  assign w_div_zero = io_md.op[2] && (io_md.dataB == '0);
  assign w_ovf      = io_md.op[2] && !io_md.op[0] &&
                      (io_md.dataA == {1'b1, {(N-1){1'b0}}}) && (io_md.dataB == '1);
  assign w_fast     = w_div_zero || w_ovf;
  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = io_md.op[1] ? io_md.dataA : '1;
    else if (w_ovf)
      w_fast_res = io_md.op[1] ? '0 : io_md.dataA;
  end

  // Multiplier lives in the low half of the product register and shifts out.
  assign w_mul_sum   = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_a_mag} : '0);
  assign w_div_shift = {r_rem, r_quot[N-1]};
  assign w_div_diff  = w_div_shift - {2'b00, r_b_mag};
  assign w_div_ge    = !w_div_diff[N+1];

  assign w_prod_fix = (r_neg_a ^ r_neg_b) ? (~r_prod + 1'b1) : r_prod;
  assign w_quot_fix = (r_neg_a ^ r_neg_b) ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fix  = r_neg_a ? (~r_rem[N-1:0] + 1'b1) : r_rem[N-1:0];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'd0:                w_fix_res = w_prod_fix[N-1:0];
      3'd1, 3'd2, 3'd3:    w_fix_res = w_prod_fix[2*N-1:N];
      3'd4, 3'd5:          w_fix_res = w_quot_fix;
      default:             w_fix_res = w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_fast ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CW'(N-1)) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_DONE;
      S_DONE: if (io_md.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (io_md.flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_prod  <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else if (io_md.flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= io_md.op;
          r_neg_a <= w_neg_a;
          r_neg_b <= w_neg_b;
          r_a_mag <= w_a_mag;
          r_b_mag <= w_b_mag;
          r_prod  <= {{N{1'b0}}, w_b_mag};
          r_quot  <= w_a_mag;
          r_rem   <= '0;
          r_cnt   <= '0;
          if (w_fast) begin
            r_out  <= w_fast_res;
            r_zero <= (w_fast_res == '0);
            r_neg  <= w_fast_res[N-1];
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[2]) begin
            r_rem  <= w_div_ge ? w_div_diff[N:0] : w_div_shift[N:0];
            r_quot <= {r_quot[N-2:0], w_div_ge};
          end else begin
            r_prod <= {w_mul_sum, r_prod[N-1:1]};
          end
        end
        S_FIX: begin
          r_cnt  <= '0;
          r_out  <= w_fix_res;
          r_zero <= (w_fix_res == '0);
          r_neg  <= w_fix_res[N-1];
        end
        default: ;
      endcase
    end
  end

  assign io_md.in_ready  = (r_state == S_IDLE);
  assign io_md.out_valid = (r_state == S_DONE);
  assign io_md.out       = r_out;
  assign io_md.Zero      = r_zero;
  assign io_md.Negative  = r_neg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at N=8: arithmetic, fast path, latency,
// backpressure, flush and asynchronous reset.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mul_div_unit_if #(.N(8)) bus ();
  mul_div_unit #(.N(8)) dut (.clk(clk), .reset(reset), .io_md(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges counted from the accepting edge (inclusive) until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input logic ez,
                        input logic en, input int exp_lat);
    int lat;
    bus.op = o; bus.dataA = a; bus.dataB = b; bus.in_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".out"}, 32'(bus.out), 32'(exp));
    chk({tag, ".zero"}, 32'(bus.Zero), 32'(ez));
    chk({tag, ".neg"}, 32'(bus.Negative), 32'(en));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, ".vld_off"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0;
    bus.dataA = '0; bus.dataB = '0; bus.out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out", 32'(bus.out), 32'd0);
    chk("rst.zero", 32'(bus.Zero), 32'd0);
    chk("rst.neg", 32'(bus.Negative), 32'd0);

    run_op("mul",    3'd0, 8'hFD, 8'h05, 8'hF1, 1'b0, 1'b1, 10);
    run_op("mulh",   3'd1, 8'h80, 8'h80, 8'h40, 1'b0, 1'b0, 10);
    run_op("mulhu",  3'd3, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b1, 10);
    run_op("mulhsu", 3'd2, 8'hFF, 8'h02, 8'hFF, 1'b0, 1'b1, 10);
    run_op("div",    3'd4, 8'hF9, 8'h02, 8'hFD, 1'b0, 1'b1, 10);
    run_op("rem",    3'd6, 8'hF9, 8'h02, 8'hFF, 1'b0, 1'b1, 10);
    run_op("divu",   3'd5, 8'hF9, 8'h02, 8'h7C, 1'b0, 1'b0, 10);
    run_op("remu",   3'd7, 8'hF9, 8'h02, 8'h01, 1'b0, 1'b0, 10);
    run_op("divu0",  3'd5, 8'h2A, 8'h00, 8'hFF, 1'b0, 1'b1, 1);
    run_op("rem0",   3'd6, 8'h2A, 8'h00, 8'h2A, 1'b0, 1'b0, 1);
    run_op("divovf", 3'd4, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 1);
    run_op("removf", 3'd6, 8'h80, 8'hFF, 8'h00, 1'b1, 1'b0, 1);

    // Backpressure: DIVU 100/7 = 14 held while a MUL 3*4 request waits.
    bus.op = 3'd5; bus.dataA = 8'h64; bus.dataB = 8'h07; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp.lat", 32'(lat), 32'd10);
    bus.op = 3'd0; bus.dataA = 8'h03; bus.dataB = 8'h04; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.hold_out", 32'(bus.out), 32'h0E);
      chk("bp.hold_vld", 32'(bus.out_valid), 32'd1);
      chk("bp.hold_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp.rel_vld", 32'(bus.out_valid), 32'd0);
    chk("bp.rel_rdy", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp.accepted", 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    chk("bp.next_lat", 32'(lat), 32'd10);
    chk("bp.next_out", 32'(bus.out), 32'h0C);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Flush mid-divide: no result ever appears and out keeps 0x0C.
    bus.op = 3'd4; bus.dataA = 8'h50; bus.dataB = 8'h03; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush.rdy", 32'(bus.in_ready), 32'd1);
    chk("flush.vld", 32'(bus.out_valid), 32'd0);
    chk("flush.out", 32'(bus.out), 32'h0C);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("flush.never_vld", 32'(seen), 32'd0);

    bus.flush = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_idle.rdy", 32'(bus.in_ready), 32'd1);
    chk("flush_idle.vld", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-CALC, checked before any further clock edge.
    bus.op = 3'd0; bus.dataA = 8'h07; bus.dataB = 8'h09; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("areset.busy", 32'(bus.in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("areset.rdy", 32'(bus.in_ready), 32'd1);
    chk("areset.vld", 32'(bus.out_valid), 32'd0);
    chk("areset.out", 32'(bus.out), 32'd0);
    #2 reset = 1'b0;
    step();
    run_op("post_rst_remu", 3'd7, 8'h64, 8'h07, 8'h02, 1'b0, 1'b0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit implementing the full RISC-V M-extension operation set, parametrised in width (N=64 for RV64, N=8 for unit benches).
- Sits beside the combinational ULA in the execute stage; the pipeline issues operations through a valid/ready handshake and stalls until the result is handed back.
- Computes one radix-2 step per cycle (shift-add multiply, restoring divide). Divide-by-zero and signed overflow are resolved on a fast path.

Parameters:
N  64  operand/result width in bits; must be at least 4 and even.
CW  $clog2(N)+1  iteration-counter width (derived, not overridable).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous abort; discards any operation in flight.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept a request (high only in IDLE).
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
dataA  input  N  rs1 (multiplicand or dividend).
dataB  input  N  rs2 (multiplier or divisor).
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out  output  N  result.
Zero  output  1  out == 0; qualified by out_valid.
Negative  output  1  out[N-1]; qualified by out_valid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=1; out_valid=0; out=0; Zero=0; Negative=0; counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1.
  - On in_valid at a rising edge: latch op, dataA and dataB; record the sign flags.
  - Signed operands are converted to magnitudes: MULH treats both as signed; MULHSU treats A signed and B unsigned; DIV/REM treat both as signed.
  - Normal operations go to CALC with counter=0.
- Fast path, taken from IDLE directly to DONE at the accepting edge:
  - Divide by zero (dataB==0): DIV/DIVU -> all ones; REM/REMU -> dataA.
  - Signed overflow (DIV/REM, dataA==1<<(N-1) and dataB==all ones): DIV -> dataA; REM -> 0.
- CALC: exactly N edges, one iteration per edge; the counter increments and CALC exits to FIX when counter==N-1.
  - Multiply uses a 2N-bit product register.
  - Divide uses an N-bit quotient and an N+1-bit partial remainder.
- FIX: one edge. Negates the result where the signs require it, then selects the output:
  - MUL: low N bits of the product.
  - MULH*: high N bits of the product.
  - DIV: quotient negated if sign(A) xor sign(B).
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: unsigned quotient/remainder.
  - FIX goes to DONE.
- Latency: for normal operations, out_valid rises after the (N+2)th rising edge following the accepting edge (N CALC edges, 1 FIX edge, plus the accepting edge). The fast path has out_valid high in the cycle right after the accepting edge.
- DONE: out_valid=1. out, Zero and Negative stay stable until out_ready is sampled high; then out_valid=0 and the state returns to IDLE at that edge.
  - in_ready is low in DONE, so there are no back-to-back accepts. The earliest next accept is the edge after the handoff.
- flush has priority over all transitions. At the next edge: state=IDLE, out_valid=0, and the operation is discarded. out keeps its last value.
  - flush in IDLE together with in_valid: the request is not accepted.
- in_valid while not in IDLE is ignored; the operand registers are unaffected.
- reset asserted mid-operation: immediate return to reset values, with no handshake completion.
- All arithmetic is modulo 2^N or 2^2N. No exception outputs; RISC-V semantics apply.

Test Plan (N=8):
1. MUL -3 (0xFD) x 5 (0x05) -> out=0xF1, Negative=1. out_valid rises exactly 10 edges after the accepting edge.
2. MULH 0x80 x 0x80 -> 0x40; MULHU 0xFF x 0xFF -> 0xFE; MULHSU 0xFF x 0x02 -> 0xFF. Flags are correct for each.
3. DIV 0xF9 (-7) / 0x02 -> 0xFD (-3); REM same operands -> 0xFF (-1); DIVU 0xF9/0x02 -> 0x7C; REMU -> 0x01.
4. DIVU 0x2A / 0 -> 0xFF; REM 0x2A / 0 -> 0x2A; DIV 0x80 / 0xFF -> 0x80; REM 0x80 / 0xFF -> 0x00 with Zero=1. Each has out_valid one edge after accept.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable and in_ready stays 0 while in_valid is held high. Release out_ready -> IDLE; the next op is accepted one edge later.
6. Issue DIV, then assert flush at iteration 3 -> IDLE next edge with out_valid never asserted. Separately, pulse reset mid-CALC -> in_ready=1 and out_valid=0 immediately, with no clock edge required.
